// File: rtl/shadow_pkg.sv
// Shared definitions for the shadow capture chains and their dump scheduler.
package shadow_pkg;

  localparam int DEFAULT_NUM_CHAINS  = 4;
  localparam int DEFAULT_CHAIN_LEN   = 32;
  localparam int DEFAULT_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    SCHED_IDLE    = 2'd0,
    SCHED_CAPTURE = 2'd1,
    SCHED_DUMP    = 2'd2,
    SCHED_FINISH  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/shadow_next_chain.sv
// Priority finder: lowest enabled chain index above base (or from 0 when first=1).
module shadow_next_chain #(
  parameter int NUM_CHAINS = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic [NUM_CHAINS-1:0] enables,
  input  logic [ID_WIDTH-1:0]   base,
  input  logic                  first,
  output logic [ID_WIDTH-1:0]   next,
  output logic                  none
);

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    next = '0;
    none = 1'b1;
    for (int i = NUM_CHAINS - 1; i >= 0; i--) begin
      if (enables[i] && (first || (i > int'(base)))) begin
        next = ID_WIDTH'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/shadow_dump_sched.sv
// Capture-and-dump sequencer for a bank of shadow chains.
// Optional per-chain participation mask: define SHADOW_SCHED_MASK_EN.
module shadow_dump_sched
  import shadow_pkg::*;
#(
  parameter int NUM_CHAINS  = DEFAULT_NUM_CHAINS,
  parameter int CHAIN_LEN   = DEFAULT_CHAIN_LEN,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
  parameter int ID_WIDTH    = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
`ifdef SHADOW_SCHED_MASK_EN
  input  logic [NUM_CHAINS-1:0] chain_mask,
`endif
  input  logic [NUM_CHAINS-1:0] chain_q,
  output logic [NUM_CHAINS-1:0] c_en,
  output logic [NUM_CHAINS-1:0] d_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_bit,
  output logic [ID_WIDTH-1:0]   out_chain,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output sched_state_t          sched_state
);

  localparam logic [COUNT_WIDTH-1:0] LAST_BIT = COUNT_WIDTH'(CHAIN_LEN - 1);

  sched_state_t           state_q, state_d;
  logic [ID_WIDTH-1:0]    idx_q, idx_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   busy_q;
  logic [NUM_CHAINS-1:0]  en_vec;
  logic [ID_WIDTH-1:0]    nxt_idx;
  logic                   nxt_none;
  logic                   last_bit;
  logic                   hs;

`ifdef SHADOW_SCHED_MASK_EN
  logic [NUM_CHAINS-1:0] mask_q;

  // Mask is frozen on the accepted start so mid-operation changes cannot skew the dump.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mask_q <= '0;
    else if (state_q == SCHED_IDLE && start && !abort) mask_q <= chain_mask;
  end
  assign en_vec = mask_q;
`else
  assign en_vec = '1;
`endif

  // Stream handshake: a beat transfers in any cycle with out_valid & out_ready;
  // out_valid never depends on out_ready, and the payload holds while stalled.
  assign last_bit = (cnt_q == LAST_BIT);
  assign hs       = (state_q == SCHED_DUMP) && out_ready;

  shadow_next_chain #(
    .NUM_CHAINS(NUM_CHAINS),
    .ID_WIDTH  (ID_WIDTH)
  ) u_next (
    .enables(en_vec),
    .base   (idx_q),
    .first  (state_q != SCHED_DUMP),
    .next   (nxt_idx),
    .none   (nxt_none)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SCHED_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != SCHED_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      SCHED_IDLE: begin
        if (start) state_d = SCHED_CAPTURE;
        idx_d = '0;
        cnt_d = '0;
      end
      SCHED_CAPTURE: begin
        cnt_d = '0;
        if (nxt_none) begin
          state_d = SCHED_FINISH;
          idx_d   = '0;
        end else begin
          state_d = SCHED_DUMP;
          idx_d   = nxt_idx;
        end
      end
      SCHED_DUMP: begin
        if (hs) begin
          if (last_bit) begin
            cnt_d = '0;
            if (nxt_none) begin
              state_d = SCHED_FINISH;
              idx_d   = '0;
            end else begin
              idx_d = nxt_idx;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      SCHED_FINISH: state_d = SCHED_IDLE;
      default:      state_d = SCHED_IDLE;
    endcase
    if (abort) begin
      state_d = SCHED_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  always_comb begin
    c_en      = '0;
    d_en      = '0;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_chain = '0;
    out_last  = 1'b0;
    done      = 1'b0;
    case (state_q)
      SCHED_CAPTURE: c_en = en_vec;
      SCHED_DUMP: begin
        out_valid   = 1'b1;
        out_bit     = chain_q[idx_q];
        out_chain   = idx_q;
        out_last    = last_bit;
        d_en[idx_q] = out_ready;
      end
      SCHED_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  assign busy        = busy_q;
  assign sched_state = state_q;

endmodule

// File: tb/tb_shadow_dump_sched.sv
// Directed bench for shadow_dump_sched with four 8-bit modelled chains.
module tb_shadow_dump_sched;
  import shadow_pkg::*;

  localparam int N   = 4;
  localparam int LEN = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic out_ready = 1'b0;
  logic [N-1:0] chain_mask = '1;
  logic [N-1:0] chain_q, c_en, d_en;
  logic out_valid, out_bit, out_last, busy, done;
  logic [1:0] out_chain;
  sched_state_t sched_state;

  logic [7:0] pre [N] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
  logic [7:0] sreg [N];

  typedef struct {
    logic       ready;
    logic       valid;
    logic       bit_v;
    logic [1:0] chain;
    logic       last;
    logic [3:0] d_en;
    logic       done;
  } vec_t;

  vec_t tbl [64];
  int n_tbl;
  int tests = 0;
  int fails = 0;
  int shifts = 0;

  always #5 clk = ~clk;

  shadow_dump_sched #(.NUM_CHAINS(N), .CHAIN_LEN(LEN), .COUNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
`ifdef SHADOW_SCHED_MASK_EN
    .chain_mask (chain_mask),
`endif
    .chain_q    (chain_q),
    .c_en       (c_en),
    .d_en       (d_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bit    (out_bit),
    .out_chain  (out_chain),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .sched_state(sched_state)
  );

  // Behavioural shadow chains: parallel load on c_en, MSB-first shift on d_en.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) sreg[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (c_en[i]) sreg[i] <= pre[i];
        else if (d_en[i]) sreg[i] <= {sreg[i][6:0], 1'b0};
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) chain_q[i] = sreg[i][7];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected per-cycle stream; ready drops for two cycles after stall_at.
  task automatic build(input logic [3:0] mask, input int stall_at);
    int en_list[$];
    int total, b, c, ch, k;
    logic rdy;
    for (int i = 0; i < N; i++) if (mask[i]) en_list.push_back(i);
    total = en_list.size() * LEN;
    b = 0;
    c = 0;
    while (b < total) begin
      rdy = !(stall_at >= 0 && (c == stall_at + 1 || c == stall_at + 2));
      ch = en_list[b / LEN];
      k  = b % LEN;
      tbl[c].ready = rdy;
      tbl[c].valid = 1'b1;
      tbl[c].bit_v = pre[ch][7-k];
      tbl[c].chain = 2'(ch);
      tbl[c].last  = (k == LEN - 1);
      tbl[c].d_en  = rdy ? 4'(1 << ch) : 4'b0;
      tbl[c].done  = 1'b0;
      if (rdy) b++;
      c++;
    end
    tbl[c].ready = 1'b1;
    tbl[c].valid = 1'b0;
    tbl[c].bit_v = 1'b0;
    tbl[c].chain = 2'b0;
    tbl[c].last  = 1'b0;
    tbl[c].d_en  = 4'b0;
    tbl[c].done  = 1'b1;
    n_tbl = c + 1;
  endtask

  task automatic do_start(input logic [3:0] mask);
    logic [3:0] eff;
`ifdef SHADOW_SCHED_MASK_EN
    eff = mask;
`else
    eff = 4'hF;
`endif
    start = 1'b1;
    chain_mask = mask;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    chk("cap_state", 32'(sched_state), 32'(SCHED_CAPTURE));
    chk("cap_c_en", 32'(c_en), 32'(eff));
    chk("cap_valid", 32'(out_valid), 32'd0);
    chk("cap_d_en", 32'(d_en), 32'd0);
    chk("cap_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic run(input int start_at, input int stop_at, input logic abort_on);
    for (int c = 0; c < n_tbl; c++) begin
      out_ready = tbl[c].ready;
      start = (c == start_at);
      abort = abort_on && (c == stop_at);
      #1;
      chk($sformatf("c%0d valid", c), 32'(out_valid), 32'(tbl[c].valid));
      if (tbl[c].valid) begin
        chk($sformatf("c%0d bit", c), 32'(out_bit), 32'(tbl[c].bit_v));
        chk($sformatf("c%0d chain", c), 32'(out_chain), 32'(tbl[c].chain));
        chk($sformatf("c%0d last", c), 32'(out_last), 32'(tbl[c].last));
      end
      chk($sformatf("c%0d d_en", c), 32'(d_en), 32'(tbl[c].d_en));
      chk($sformatf("c%0d done", c), 32'(done), 32'(tbl[c].done));
      chk($sformatf("c%0d busy", c), 32'(busy), 32'd1);
      shifts += $countones(d_en);
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      if (c == stop_at) break;
    end
    out_ready = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(sched_state), 32'(SCHED_IDLE));
    chk("rst_outs", 32'({c_en, d_en, out_valid, out_last, done, busy, out_bit}), 32'd0);
    chk("rst_chain", 32'(out_chain), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Full dump, ready held high.
    shifts = 0;
    do_start(4'hF);
    build(4'hF, -1);
    run(-1, -1, 1'b0);
    chk("full_shifts", 32'(shifts), 32'd32);
    chk("full_idle_busy", 32'(busy), 32'd0);
    chk("full_idle_done", 32'(done), 32'd0);

    // Stall 1,0,0,1 inside chain 1, with an ignored start mid-dump.
    shifts = 0;
    do_start(4'hF);
    build(4'hF, 8);
    run(4, -1, 1'b0);
    chk("stall_shifts", 32'(shifts), 32'd32);
    chk("stall_idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("no_queued_start", 32'(sched_state), 32'(SCHED_IDLE));
    chk("no_queued_c_en", 32'(c_en), 32'd0);

    // Abort on the 5th beat of chain 2, then restart from chain 0.
    do_start(4'hF);
    build(4'hF, -1);
    run(-1, 20, 1'b1);
    chk("abort_state", 32'(sched_state), 32'(SCHED_IDLE));
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    do_start(4'hF);
    build(4'hF, -1);
    run(-1, -1, 1'b0);

    // Asynchronous reset in the middle of chain 1.
    do_start(4'hF);
    build(4'hF, -1);
    run(-1, 10, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_state", 32'(sched_state), 32'(SCHED_IDLE));
    chk("arst_outs", 32'({c_en, d_en, out_valid, out_last, done, busy, out_bit}), 32'd0);
    chk("arst_chain", 32'(out_chain), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("arst_after_busy", 32'(busy), 32'd0);

`ifdef SHADOW_SCHED_MASK_EN
    shifts = 0;
    do_start(4'b1010);
    build(4'b1010, -1);
    run(-1, -1, 1'b0);
    chk("mask_shifts", 32'(shifts), 32'd16);
    shifts = 0;
    do_start(4'b0000);
    build(4'b0000, -1);
    run(-1, -1, 1'b0);
    chk("mask0_shifts", 32'(shifts), 32'd0);
    chk("mask0_busy", 32'(busy), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shadow_dump_sched.md
# shadow_dump_sched

Sequencing controller for a bank of shadow capture chains. On a start request it issues a single capture strobe to every enabled chain. It then drains the chains one at a time, bit-serially, onto a valid/ready stream toward the host-side debug link. It owns each chain's capture and dump enables, so no chain shifts unless the consumer has accepted the bit.

## Interface
- `NUM_CHAINS`, 4: number of shadow chains managed; must be ≥1.
- `CHAIN_LEN`, 32: bits per chain; all chains equal length; 1 ≤ CHAIN_LEN ≤ 2^COUNT_WIDTH.
- `COUNT_WIDTH`, 16: width of the bit counter.
- `ID_WIDTH`, $clog2(NUM_CHAINS) (min 1): width of the chain index.
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: capture-and-dump request, honoured only in IDLE.
- `abort` in 1: abandon the current operation.
- `chain_mask` in NUM_CHAINS: 1 = chain participates (only with the mask macro).
- `chain_q` in NUM_CHAINS: serial output bit of each chain, valid before its shift.
- `c_en` out NUM_CHAINS: per-chain capture strobe.
- `d_en` out NUM_CHAINS: per-chain dump-shift enable.
- `out_valid` out 1: stream bit valid.
- `out_ready` in 1: consumer accepts bit.
- `out_bit` out 1: current serial bit.
- `out_chain` out ID_WIDTH: index of the chain being drained.
- `out_last` out 1: final bit of the current chain.
- `busy` out 1: not IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, CAPTURE, DUMP, FINISH.
- IDLE → CAPTURE on `start`=1.
- CAPTURE lasts exactly one cycle.
  - `c_en` equals the enabled-chain vector; all other outputs are 0.
  - Next state: DUMP at the lowest enabled chain, bit counter = 0.
- DUMP:
  - `out_valid`=1, `out_bit`=`chain_q[out_chain]`.
  - `d_en[out_chain]` = `out_valid & out_ready` (combinational). All other `d_en` bits are 0.
  - Each handshake increments the bit counter.
  - `out_last` = (bit counter == CHAIN_LEN-1).
  - Handshake with `out_last` → advance to the next-higher enabled chain with counter 0. If none remains → FINISH.
- FINISH: `done`=1 for one cycle, then IDLE.
- `abort` has priority over every transition:
  - Next state is IDLE, counter and index are cleared, no `done`.
  - Any `d_en` in the abort cycle still follows the handshake rule.
- `start` outside IDLE is ignored and not queued.
- `start` and `abort` together in IDLE → stay IDLE.

## Timing
- Reset values:
  - State IDLE; `c_en`, `d_en`, `out_valid`, `out_last`, `done`, `busy` all 0.
  - `out_chain` 0, `out_bit` 0.
- Latency:
  - `start` sampled at edge N.
  - `c_en` is high during cycle N+1.
  - First `out_valid` in cycle N+2.
- `busy` is registered. It is high from CAPTURE through FINISH inclusive.
- Throughput: one bit per cycle while `out_ready`=1. Stalls hold `out_bit`, `out_chain` and `out_last` stable.
- Chain switch costs no bubble: the last bit of chain k is followed in the next cycle by the first bit of chain k+1.
- Total stream length is (enabled chains) × CHAIN_LEN beats.
- Reset asserted mid-dump returns to IDLE immediately. All enables drop asynchronously.

## Configuration
- `SHADOW_SCHED_MASK_EN` defined:
  - `chain_mask` is sampled once on the accepted `start` and held for the whole operation.
  - Disabled chains receive no `c_en` and are skipped in DUMP.
  - An all-zero mask goes CAPTURE → FINISH: `done` fires, no beats are emitted.
- `SHADOW_SCHED_MASK_EN` not defined:
  - The `chain_mask` port is absent.
  - All NUM_CHAINS chains always participate.

## Structure
- Shared package `shadow_pkg` holds:
  - the state enum (`SCHED_IDLE`, `SCHED_CAPTURE`, `SCHED_DUMP`, `SCHED_FINISH`);
  - the default NUM_CHAINS, CHAIN_LEN and COUNT_WIDTH constants, shared with the chain instances.
- One sub-module, `shadow_next_chain`: a combinational priority finder returning the next enabled index above a given index, plus a none-left flag.

## Test plan
- NUM_CHAINS=4, CHAIN_LEN=8, `out_ready`=1, `start` pulse → `c_en`=4'b1111 for one cycle, then 32 consecutive beats; `out_last` on beats 8/16/24/32; `done` one cycle after beat 32.
- Chains preloaded with 0xA5,0x3C,0xFF,0x00, MSB first → `out_bit` stream reproduces those bytes in chain order 0..3.
- `out_ready` toggled 1,0,0,1 during chain 1 → `d_en` pulses only on accepted cycles; `out_bit` stable while stalled; still exactly 32 shifts in total.
- `abort` on the 5th beat of chain 2 → IDLE next cycle, `busy`=0, no `done`; a new `start` restarts at chain 0, bit 0.
- With `SHADOW_SCHED_MASK_EN`, `chain_mask`=4'b1010 → `c_en`=4'b1010; beats from chains 1 and 3 only (16 beats). Mask 4'b0000 → `done` two cycles after `start`, zero beats.
- `rst` asserted low mid-DUMP → all outputs 0 immediately; `start` while busy → ignored, beat count unchanged.
